// File: rtl/krnl_acc_axil_ctrl_slave_gen.sv
// krnl_acc_axil_ctrl_slave_gen
// AXI4-Lite control slave for an accelerator kernel: ap_ctrl_chain CTRL register,
// GIE/IER/ISR interrupt block and a bank of NUM_CFG_REGS 32-bit config registers
// exported to the datapath on a flat bus. AW and W are buffered independently in
// one-entry holders; unmapped addresses answer SLVERR.
// Optional feature macro: CTRL_AUTO_RESTART_EN (makes CTRL[7] auto_restart writable).

module krnl_acc_axil_ctrl_slave_gen #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int NUM_CFG_REGS = 16,
    parameter int CFG_BASE     = 'h010
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [C_ADDR_WIDTH-1:0]     AWADDR,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [31:0]                 WDATA,
    input  logic [3:0]                  WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [C_ADDR_WIDTH-1:0]     ARADDR,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [31:0]                 RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic                        ap_start,
    input  logic                        ap_done,
    input  logic                        ap_idle,
    input  logic                        ap_ready,
    output logic                        ap_continue,
    output logic                        interrupt,
    output logic [32*NUM_CFG_REGS-1:0]  cfg_regs
);

    localparam int          IDX_W         = (NUM_CFG_REGS > 1) ? $clog2(NUM_CFG_REGS) : 1;
    localparam int unsigned CFG_BASE_WORD = CFG_BASE / 4;
    localparam int unsigned CFG_END_WORD  = CFG_BASE_WORD + NUM_CFG_REGS;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;

    typedef enum logic [2:0] {
        SEL_CTRL = 3'd0,
        SEL_GIE  = 3'd1,
        SEL_IER  = 3'd2,
        SEL_ISR  = 3'd3,
        SEL_CFG  = 3'd4,
        SEL_NONE = 3'd5
    } sel_e;

    // Map a byte address onto a register group; sub-word addresses are unmapped.
    function automatic sel_e decode_sel(input logic [C_ADDR_WIDTH-1:0] addr);
        int unsigned word;
        sel_e        sel;
        word = 32'(addr[C_ADDR_WIDTH-1:2]);
        if (addr[1:0] != 2'b00) begin
            sel = SEL_NONE;
        end else if (word == 32'd0) begin
            sel = SEL_CTRL;
        end else if (word == 32'd1) begin
            sel = SEL_GIE;
        end else if (word == 32'd2) begin
            sel = SEL_IER;
        end else if (word == 32'd3) begin
            sel = SEL_ISR;
        end else if ((word >= CFG_BASE_WORD) && (word < CFG_END_WORD)) begin
            sel = SEL_CFG;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

    // Config bank index of an address already known to hit the bank.
    function automatic logic [IDX_W-1:0] cfg_index(input logic [C_ADDR_WIDTH-1:0] addr);
        int unsigned word;
        word = 32'(addr[C_ADDR_WIDTH-1:2]);
        return IDX_W'(word - CFG_BASE_WORD);
    endfunction

    // Byte-lane merge of new data into an old register value.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Channel state
    logic                    aw_full_q, aw_full_d;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                    w_full_q,  w_full_d;
    logic [31:0]             w_data_q,  w_data_d;
    logic [3:0]              w_strb_q,  w_strb_d;
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    rvalid_q,  rvalid_d;
    logic [31:0]             rdata_q,   rdata_d;
    logic [1:0]              rresp_q,   rresp_d;

    // Control / interrupt state
    logic                    ap_start_q, ap_start_d;
    logic                    done_q,     done_d;
    logic                    idle_q,     ready_q;
    logic                    cont_q,     cont_d;
    logic                    auto_restart_q;
    logic                    gie_q,      gie_d;
    logic [1:0]              ier_q,      ier_d;
    logic [1:0]              isr_q,      isr_d;
    logic                    irq_q;

    // Config bank
    logic [31:0]             cfg_q [NUM_CFG_REGS];
    logic [31:0]             cfg_d [NUM_CFG_REGS];

    // Decoded strobes
    sel_e                    wr_sel_s, rd_sel_s;
    logic [IDX_W-1:0]        wr_idx_s, rd_idx_s;
    logic                    commit_s, rd_hs_s;
    logic                    wr_b0_s;
    logic                    wr_ctrl_s, wr_gie_s, wr_ier_s, wr_isr_s;
    logic [31:0]             rd_data_s;

    assign wr_sel_s  = decode_sel(aw_addr_q);
    assign wr_idx_s  = cfg_index(aw_addr_q);
    assign rd_sel_s  = decode_sel(ARADDR);
    assign rd_idx_s  = cfg_index(ARADDR);
    // A write commits only once both halves are held and the B slot is free.
    assign commit_s  = aw_full_q & w_full_q & ~bvalid_q;
    assign rd_hs_s   = ARVALID & ~rvalid_q;
    assign wr_b0_s   = commit_s & w_strb_q[0];
    assign wr_ctrl_s = wr_b0_s & (wr_sel_s == SEL_CTRL);
    assign wr_gie_s  = wr_b0_s & (wr_sel_s == SEL_GIE);
    assign wr_ier_s  = wr_b0_s & (wr_sel_s == SEL_IER);
    assign wr_isr_s  = wr_b0_s & (wr_sel_s == SEL_ISR);

    // Read mux over the current register values (same-cycle writes are not visible).
    always_comb begin
        rd_data_s = 32'd0;
        case (rd_sel_s)
            SEL_CTRL: rd_data_s = {24'd0, auto_restart_q, 2'b00, 1'b0,
                                   ready_q, idle_q, done_q, ap_start_q};
            SEL_GIE:  rd_data_s = {31'd0, gie_q};
            SEL_IER:  rd_data_s = {30'd0, ier_q};
            SEL_ISR:  rd_data_s = {30'd0, isr_q};
            SEL_CFG:  rd_data_s = cfg_q[rd_idx_s];
            default:  rd_data_s = 32'd0;
        endcase
    end

    // Next state of the AW/W holders and the B/R response channels.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (commit_s) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_sel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && BREADY) begin
            bvalid_d  = 1'b0;
        end else begin
            bvalid_d  = bvalid_q;
        end

        if (AWVALID && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = AWADDR;
        end else begin
            aw_addr_d = aw_addr_q;
        end

        if (WVALID && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end else begin
            w_data_d = w_data_q;
        end

        if (rd_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_s;
            rresp_d  = (rd_sel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Register the AXI channel state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Next state of the kernel control and interrupt registers.
    always_comb begin
        ap_start_d = ap_start_q;
        done_d     = done_q;
        cont_d     = 1'b0;
        gie_d      = gie_q;
        ier_d      = ier_q;
        isr_d      = isr_q;

        // Software start wins over a simultaneous ap_ready.
        if (wr_ctrl_s && w_data_q[0]) begin
            ap_start_d = 1'b1;
        end else if (ap_ready && !auto_restart_q) begin
            ap_start_d = 1'b0;
        end else begin
            ap_start_d = ap_start_q;
        end

        // Sticky done: a new ap_done beats the clear-on-read.
        if (ap_done) begin
            done_d = 1'b1;
        end else if (rd_hs_s && (rd_sel_s == SEL_CTRL)) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (wr_ctrl_s) begin
            cont_d = w_data_q[4];
        end else begin
            cont_d = 1'b0;
        end

        if (wr_gie_s) begin
            gie_d = w_data_q[0];
        end else begin
            gie_d = gie_q;
        end

        if (wr_ier_s) begin
            ier_d = w_data_q[1:0];
        end else begin
            ier_d = ier_q;
        end

        // Toggle first, then OR in enabled events so an event always wins.
        if (wr_isr_s) begin
            isr_d = isr_q ^ w_data_q[1:0];
        end else begin
            isr_d = isr_q;
        end
        isr_d = isr_d | ({ap_ready, ap_done} & ier_q);
    end

    // Register kernel control, status sampling and the interrupt line.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ap_start_q <= 1'b0;
            done_q     <= 1'b0;
            idle_q     <= 1'b0;
            ready_q    <= 1'b0;
            cont_q     <= 1'b0;
            gie_q      <= 1'b0;
            ier_q      <= 2'b00;
            isr_q      <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            ap_start_q <= ap_start_d;
            done_q     <= done_d;
            idle_q     <= ap_idle;
            ready_q    <= ap_ready;
            cont_q     <= cont_d;
            gie_q      <= gie_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            irq_q      <= gie_q & (|isr_q);
        end
    end

`ifdef CTRL_AUTO_RESTART_EN
    logic auto_restart_d;

    assign auto_restart_d = wr_ctrl_s ? w_data_q[7] : auto_restart_q;

    // Software-owned auto_restart flag in CTRL[7].
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            auto_restart_q <= 1'b0;
        end else begin
            auto_restart_q <= auto_restart_d;
        end
    end
`else
    assign auto_restart_q = 1'b0;
`endif

    // Next state of the config bank: byte-masked write of the addressed entry.
    always_comb begin
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
            cfg_d[i] = cfg_q[i];
        end
        if (commit_s && (wr_sel_s == SEL_CFG)) begin
            cfg_d[wr_idx_s] = strb_merge(cfg_q[wr_idx_s], w_data_q, w_strb_q);
        end else begin
            cfg_d[wr_idx_s] = cfg_q[wr_idx_s];
        end
    end

    // Register the config bank.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                cfg_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_out
        assign cfg_regs[32*g +: 32] = cfg_q[g];
    end

    assign AWREADY     = ~aw_full_q;
    assign WREADY      = ~w_full_q;
    assign BVALID      = bvalid_q;
    assign BRESP       = bresp_q;
    assign ARREADY     = ~rvalid_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign ap_start    = ap_start_q;
    assign ap_continue = cont_q;
    assign interrupt   = irq_q;

endmodule

// File: tb/tb_krnl_acc_axil_ctrl_slave_gen.sv
// Self-checking bench for krnl_acc_axil_ctrl_slave_gen (default parameters).
// Expected B and R responses are queued when a transaction is issued and
// popped when the DUT presents the response.

module tb_krnl_acc_axil_ctrl_slave_gen;

    localparam int AW = 12;
    localparam int NR = 16;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [AW-1:0]    AWADDR;
    logic             AWVALID;
    logic             AWREADY;
    logic [31:0]      WDATA;
    logic [3:0]       WSTRB;
    logic             WVALID;
    logic             WREADY;
    logic [1:0]       BRESP;
    logic             BVALID;
    logic             BREADY;
    logic [AW-1:0]    ARADDR;
    logic             ARVALID;
    logic             ARREADY;
    logic [31:0]      RDATA;
    logic [1:0]       RRESP;
    logic             RVALID;
    logic             RREADY;
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic             ap_continue;
    logic             interrupt;
    logic [32*NR-1:0] cfg_regs;

    krnl_acc_axil_ctrl_slave_gen #(
        .C_ADDR_WIDTH (AW),
        .NUM_CFG_REGS (NR),
        .CFG_BASE     ('h010)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .ap_continue (ap_continue),
        .interrupt   (interrupt),
        .cfg_regs    (cfg_regs)
    );

    always #5 ACLK = ~ACLK;

    int          n_vec = 0;
    int          n_err = 0;
    int          cont_cnt = 0;
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];

    // Count ap_continue pulses, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (ap_continue) cont_cnt <= cont_cnt + 1;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK); #1;
        end
    endtask

    task automatic pulse_ready();
        ap_ready = 1'b1;
        @(posedge ACLK); #1;
        ap_ready = 1'b0;
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        @(posedge ACLK); #1;
        ap_done = 1'b0;
    endtask

    // Write with W issued w_delay cycles after AW; lat = cycles from W accept to BVALID.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_delay,
                             input logic [1:0] exp_resp, output int lat);
        logic aw_done, w_done, aw_hs, w_hs;
        logic [1:0] e;
        int cyc;
        exp_b_q.push_back(exp_resp);
        AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = (w_delay == 0);
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            cyc++;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin WVALID  = 1'b0; w_done  = 1'b1; end
            if (!w_done && !WVALID && cyc >= w_delay) WVALID = 1'b1;
            if (aw_done && !w_done && cyc == 1) chk_val("awready_held", 32'(AWREADY), 32'd0);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        cyc = 0;
        while (!BVALID && cyc < 64) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        lat = cyc;
        chk_val($sformatf("bvalid@%03h", addr), 32'(BVALID), 32'd1);
        e = exp_b_q.pop_front();
        chk_val($sformatf("bresp@%03h", addr), 32'(BRESP), 32'(e));
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_resp);
        int lat;
        axi_write(addr, data, strb, 0, exp_resp, lat);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        logic [33:0] e;
        int cyc;
        exp_r_q.push_back({exp_resp, exp_data});
        ARADDR = addr; ARVALID = 1'b1;
        cyc = 0;
        while (!ARREADY && cyc < 64) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        cyc = 0;
        while (!RVALID && cyc < 64) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        chk_val($sformatf("rvalid@%03h", addr), 32'(RVALID), 32'd1);
        chk_val($sformatf("arready_busy@%03h", addr), 32'(ARREADY), 32'd0);
        e = exp_r_q.pop_front();
        chk_val($sformatf("rdata@%03h", addr), RDATA, e[31:0]);
        chk_val($sformatf("rresp@%03h", addr), 32'(RRESP), 32'(e[33:32]));
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c0;
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = 32'd0; WSTRB = 4'd0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        ap_done = 1'b0; ap_idle = 1'b1; ap_ready = 1'b0;
        idle(3);

        // Reset state
        chk_val("rst_awready", 32'(AWREADY), 32'd1);
        chk_val("rst_wready", 32'(WREADY), 32'd1);
        chk_val("rst_arready", 32'(ARREADY), 32'd1);
        chk_val("rst_bvalid", 32'(BVALID), 32'd0);
        chk_val("rst_rvalid", 32'(RVALID), 32'd0);
        chk_val("rst_rdata", RDATA, 32'd0);
        chk_val("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
        chk_val("rst_ctrl_out", {29'd0, ap_start, ap_continue, interrupt}, 32'd0);
        chk_val("rst_cfg", 32'(|cfg_regs), 32'd0);
        ARESET = 1'b0;
        idle(2);

        // AW first, W three cycles later, partial strobe
        axi_write(12'h014, 32'hDEADBEEF, 4'b0011, 3, 2'b00, lat);
        chk_val("b_latency", 32'(lat), 32'd1);
        chk_val("cfg1_out", cfg_regs[63:32], 32'h0000BEEF);
        axi_read(12'h014, 32'h0000BEEF, 2'b00);

        // Byte merge on cfg0
        wr(12'h010, 32'h12345678, 4'b1111, 2'b00);
        wr(12'h010, 32'hAABBCCDD, 4'b1100, 2'b00);
        axi_read(12'h010, 32'hAABB5678, 2'b00);

        // Last cfg register and the first address past the bank
        wr(12'h04C, 32'hCAFEF00D, 4'b1111, 2'b00);
        chk_val("cfg15_out", cfg_regs[511:480], 32'hCAFEF00D);
        axi_read(12'h04C, 32'hCAFEF00D, 2'b00);
        axi_read(12'h050, 32'd0, 2'b10);
        wr(12'h050, 32'h55555555, 4'b1111, 2'b10);

        // ap_start held until ap_ready
        wr(12'h000, 32'h1, 4'b0001, 2'b00);
        chk_val("start_set", 32'(ap_start), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk_val($sformatf("start_hold%0d", i), 32'(ap_start), 32'd1);
        end
        pulse_ready();
        chk_val("start_clr", 32'(ap_start), 32'd0);
        idle(2);
        axi_read(12'h000, 32'h4, 2'b00);

        // ap_continue pulse, bit reads back 0, no start
        c0 = cont_cnt;
        wr(12'h000, 32'h10, 4'b0001, 2'b00);
        idle(2);
        chk_val("cont_pulses", 32'(cont_cnt - c0), 32'd1);
        chk_val("cont_no_start", 32'(ap_start), 32'd0);
        axi_read(12'h000, 32'h4, 2'b00);

        // Sticky done, cleared by a CTRL read
        pulse_done();
        idle(1);
        axi_read(12'h000, 32'h6, 2'b00);
        axi_read(12'h000, 32'h4, 2'b00);

        // Interrupt block
        wr(12'h004, 32'h1, 4'b0001, 2'b00);
        wr(12'h008, 32'h1, 4'b0001, 2'b00);
        chk_val("irq_idle", 32'(interrupt), 32'd0);
        pulse_done();
        idle(2);
        chk_val("irq_on_done", 32'(interrupt), 32'd1);
        axi_read(12'h00C, 32'h1, 2'b00);
        wr(12'h00C, 32'h1, 4'b0001, 2'b00);
        idle(1);
        chk_val("irq_cleared", 32'(interrupt), 32'd0);
        axi_read(12'h00C, 32'h0, 2'b00);
        pulse_ready();
        idle(2);
        axi_read(12'h00C, 32'h0, 2'b00);
        wr(12'h00C, 32'h2, 4'b0001, 2'b00);
        idle(1);
        chk_val("irq_toggle_on", 32'(interrupt), 32'd1);
        axi_read(12'h00C, 32'h2, 2'b00);
        wr(12'h00C, 32'h2, 4'b0001, 2'b00);
        idle(1);
        chk_val("irq_toggle_off", 32'(interrupt), 32'd0);
        axi_read(12'h004, 32'h1, 2'b00);
        axi_read(12'h008, 32'h1, 2'b00);

        // Done set and read-clear in the same cycle: set wins
        axi_read(12'h000, 32'h6, 2'b00);
        ap_done = 1'b1;
        fork
            axi_read(12'h000, 32'h4, 2'b00);
            begin
                @(posedge ACLK); #1;
                ap_done = 1'b0;
            end
        join
        axi_read(12'h000, 32'h6, 2'b00);
        axi_read(12'h000, 32'h4, 2'b00);

        // Unmapped access leaves everything alone
        axi_read(12'hFFC, 32'd0, 2'b10);
        wr(12'hFFC, 32'hFFFFFFFF, 4'b1111, 2'b10);
        chk_val("unm_cfg0", cfg_regs[31:0], 32'hAABB5678);
        chk_val("unm_cfg1", cfg_regs[63:32], 32'h0000BEEF);
        chk_val("unm_cfg15", cfg_regs[511:480], 32'hCAFEF00D);
        axi_read(12'h004, 32'h1, 2'b00);

        // Auto-restart
        wr(12'h000, 32'h81, 4'b0001, 2'b00);
        chk_val("ar_start", 32'(ap_start), 32'd1);
`ifdef CTRL_AUTO_RESTART_EN
        axi_read(12'h000, 32'h85, 2'b00);
        for (int i = 0; i < 3; i++) begin
            pulse_ready();
            idle(1);
            chk_val($sformatf("ar_hold%0d", i), 32'(ap_start), 32'd1);
        end
        wr(12'h000, 32'h0, 4'b0001, 2'b00);
        chk_val("ar_off_hold", 32'(ap_start), 32'd1);
        pulse_ready();
        chk_val("ar_off_clr", 32'(ap_start), 32'd0);
`else
        axi_read(12'h000, 32'h5, 2'b00);
        pulse_ready();
        chk_val("ar_dis_clr", 32'(ap_start), 32'd0);
`endif
        idle(2);
        axi_read(12'h000, 32'h4, 2'b00);

        // Reset in the middle of a write: AW held, W never sent
        AWADDR = 12'h010; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        chk_val("mid_aw_held", 32'(AWREADY), 32'd0);
        ARESET = 1'b1;
        #1;
        chk_val("mid_awready", 32'(AWREADY), 32'd1);
        chk_val("mid_irq", 32'(interrupt), 32'd0);
        chk_val("mid_cfg", 32'(|cfg_regs), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        idle(2);
        chk_val("mid_bvalid", 32'(BVALID), 32'd0);
        wr(12'h010, 32'h00000011, 4'b1111, 2'b00);
        axi_read(12'h010, 32'h00000011, 2'b00);
        axi_read(12'h014, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
